regfile_sb: RTL and testbench

REGFILE_SB -- requirements
Module: regfile_sb

---
 rtl/regfile_sb.sv | 95 +++++++++
 tb/tb_regfile_sb.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// Register file with write-through bypass, multiple combinational read ports and a
// per-register pending-write scoreboard for issue/writeback hazard tracking.
module regfile_sb #(
    parameter int ADDRESS_WIDTH = 5,
    parameter int DATA_WIDTH    = 32,
    parameter int NUM_READ      = 2,
    parameter int A0_INDEX      = 10
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_READ*ADDRESS_WIDTH-1:0] ad_rd,
    output logic [NUM_READ*DATA_WIDTH-1:0]    rd_data,
    output logic [NUM_READ-1:0]               rd_busy,
    input  logic [ADDRESS_WIDTH-1:0]          ad3,
    input  logic                              WE3,
    input  logic [DATA_WIDTH-1:0]             WD3,
    input  logic                              iss_valid,
    input  logic [ADDRESS_WIDTH-1:0]          iss_rd,
    output logic [DATA_WIDTH-1:0]             a0,
    output logic [2**ADDRESS_WIDTH-1:0]       busy_vec
);

    localparam int DEPTH = 2**ADDRESS_WIDTH;

    if (NUM_READ < 1 || NUM_READ > 4) begin : g_bad_num_read
        $error("regfile_sb: NUM_READ must be in 1..4");
    end
    if (A0_INDEX < 0 || A0_INDEX >= DEPTH) begin : g_bad_a0_index
        $error("regfile_sb: A0_INDEX must be below 2**ADDRESS_WIDTH");
    end

    localparam logic [ADDRESS_WIDTH-1:0] A0_AD = ADDRESS_WIDTH'(A0_INDEX);

    logic [DATA_WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0]      busy;
    logic [DEPTH-1:0]      busy_next;

    // Issue is applied after writeback so a same-register collision leaves the new producer pending.
    always_comb begin
        busy_next = busy;
        if (WE3) begin
            busy_next[ad3] = 1'b0;
        end
        if (iss_valid) begin
            busy_next[iss_rd] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
            for (int n = 0; n < DEPTH; n++) begin
                regs[n] <= '0;
            end
        end else begin
            busy <= busy_next;
            if (WE3 && ad3 != '0) begin
                regs[ad3] <= WD3;
            end
        end
    end

    assign busy_vec = busy;

    for (genvar i = 0; i < NUM_READ; i++) begin : g_rd
        logic [ADDRESS_WIDTH-1:0] ad;
        logic                     hit;
        logic [DATA_WIDTH-1:0]    val;

        assign ad  = ad_rd[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        assign hit = WE3 && (ad3 == ad);

        always_comb begin
            val = '0;
            if (!rst && ad != '0) begin
                val = hit ? WD3 : regs[ad];
            end
        end

        assign rd_data[i*DATA_WIDTH +: DATA_WIDTH] = val;
        assign rd_busy[i] = !rst && busy[ad] && !hit;
    end

    logic a0_hit;
    assign a0_hit = WE3 && (ad3 == A0_AD);

    always_comb begin
        a0 = '0;
        if (!rst && A0_AD != '0) begin
            a0 = a0_hit ? WD3 : regs[A0_AD];
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: reset, write/read, bypass, zero register,
// scoreboard set/clear/collision and asynchronous reset.
module tb_regfile_sb;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  ad_rd;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic [4:0]  ad3;
    logic        WE3;
    logic [31:0] WD3;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic [31:0] a0;
    logic [31:0] busy_vec;

    int checks   = 0;
    int failures = 0;

    regfile_sb dut (
        .clk       (clk),
        .rst       (rst),
        .ad_rd     (ad_rd),
        .rd_data   (rd_data),
        .rd_busy   (rd_busy),
        .ad3       (ad3),
        .WE3       (WE3),
        .WD3       (WD3),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .a0        (a0),
        .busy_vec  (busy_vec)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        WE3       = 1'b0;
        ad3       = '0;
        WD3       = '0;
        iss_valid = 1'b0;
        iss_rd    = '0;
    endtask

    task automatic set_rd(input logic [4:0] p1, input logic [4:0] p0);
        ad_rd = {p1, p0};
    endtask

    // Finish the current low phase, take one rising edge, and settle 1 time unit.
    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    task automatic next_low();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        idle();
        set_rd(5'd5, 5'd0);
        #3;
        check("reset_rd0", rd_data[31:0], 64'h0);
        check("reset_rd1", rd_data[63:32], 64'h0);
        check("reset_busy_vec", busy_vec, 64'h0);
        check("reset_a0", a0, 64'h0);

        // Writes and issues during reset are ignored, bypass included.
        WE3 = 1'b1; ad3 = 5'd5; WD3 = 32'h1111_2222;
        iss_valid = 1'b1; iss_rd = 5'd5;
        #1;
        check("reset_no_bypass", rd_data[63:32], 64'h0);
        check("reset_rd_busy", rd_busy, 64'h0);
        edge_step();
        next_low();
        idle();
        rst = 1'b0;
        #1;
        check("reset_write_ignored", rd_data[63:32], 64'h0);
        check("reset_issue_ignored", busy_vec, 64'h0);

        // Write then read register 10 (mirrored on a0).
        next_low();
        WE3 = 1'b1; ad3 = 5'd10; WD3 = 32'hDEAD_BEEF;
        set_rd(5'd0, 5'd10);
        #1;
        check("a0_bypass", a0, 64'hDEAD_BEEF);
        edge_step();
        next_low();
        idle();
        #1;
        check("a0_after_write", a0, 64'hDEAD_BEEF);
        check("rd0_reg10", rd_data[31:0], 64'hDEAD_BEEF);

        // Same-cycle bypass on port 1.
        WE3 = 1'b1; ad3 = 5'd7; WD3 = 32'h55;
        set_rd(5'd7, 5'd10);
        #1;
        check("bypass_rd1", rd_data[63:32], 64'h55);
        check("bypass_other_port", rd_data[31:0], 64'hDEAD_BEEF);
        edge_step();
        next_low();
        idle();
        set_rd(5'd10, 5'd7);
        #1;
        check("rd0_reg7", rd_data[31:0], 64'h55);

        // Register 0 ignores writes and issues.
        WE3 = 1'b1; ad3 = 5'd0; WD3 = 32'hFFFF_FFFF;
        iss_valid = 1'b1; iss_rd = 5'd0;
        set_rd(5'd0, 5'd0);
        #1;
        check("zero_bypass", rd_data[31:0], 64'h0);
        edge_step();
        next_low();
        idle();
        #1;
        check("zero_rd1", rd_data[63:32], 64'h0);
        check("zero_busy", busy_vec, 64'h0);

        // Scoreboard: issue 3, hold a cycle, then write back 3.
        iss_valid = 1'b1; iss_rd = 5'd3;
        set_rd(5'd0, 5'd3);
        #1;
        check("issue_not_same_cycle", rd_busy, 64'h0);
        edge_step();
        check("issue_rd_busy", rd_busy, 64'h1);
        check("issue_busy_vec", busy_vec, 64'h8);
        next_low();
        idle();
        edge_step();
        next_low();
        WE3 = 1'b1; ad3 = 5'd3; WD3 = 32'h1234;
        #1;
        check("wb_rd_busy_comb", rd_busy, 64'h0);
        check("wb_bypass_data", rd_data[31:0], 64'h1234);
        check("wb_busy_vec_before_edge", busy_vec, 64'h8);
        edge_step();
        check("wb_busy_cleared", busy_vec, 64'h0);

        // Same-edge issue and writeback to 3: new producer wins.
        next_low();
        iss_valid = 1'b1; iss_rd = 5'd3;
        WE3 = 1'b0;
        edge_step();
        next_low();
        WE3 = 1'b1; ad3 = 5'd3; WD3 = 32'h5678;
        iss_valid = 1'b1; iss_rd = 5'd3;
        edge_step();
        check("collide_stays_busy", busy_vec, 64'h8);

        // Different registers on one edge: issue 6, write back 3.
        next_low();
        WE3 = 1'b1; ad3 = 5'd3; WD3 = 32'h9ABC;
        iss_valid = 1'b1; iss_rd = 5'd6;
        edge_step();
        check("diff_regs_busy", busy_vec, 64'h40);
        next_low();
        idle();
        set_rd(5'd6, 5'd3);
        #1;
        check("diff_regs_data", rd_data[31:0], 64'h9ABC);
        check("diff_regs_rd_busy", rd_busy, 64'h2);

        // Writeback to a non-busy register updates data only.
        WE3 = 1'b1; ad3 = 5'd9; WD3 = 32'hCAFE;
        edge_step();
        next_low();
        idle();
        set_rd(5'd9, 5'd3);
        #1;
        check("nonbusy_wb_data", rd_data[63:32], 64'hCAFE);
        check("nonbusy_wb_busy", busy_vec, 64'h40);

        // Async reset between edges, with a write held across the next edge.
        iss_valid = 1'b1; iss_rd = 5'd4;
        edge_step();
        check("pre_reset_busy", busy_vec, 64'h50);
        next_low();
        idle();
        set_rd(5'd7, 5'd10);
        #2;
        rst = 1'b1;
        #1;
        check("async_busy_vec", busy_vec, 64'h0);
        check("async_rd0", rd_data[31:0], 64'h0);
        check("async_rd1", rd_data[63:32], 64'h0);
        check("async_a0", a0, 64'h0);
        WE3 = 1'b1; ad3 = 5'd5; WD3 = 32'h7777;
        edge_step();
        next_low();
        idle();
        rst = 1'b0;
        set_rd(5'd5, 5'd10);
        #1;
        check("post_reset_reg10", rd_data[31:0], 64'h0);
        check("post_reset_reg5", rd_data[63:32], 64'h0);

        // First edge after reset release accepts writes and issues.
        WE3 = 1'b1; ad3 = 5'd12; WD3 = 32'hA5A5_0001;
        iss_valid = 1'b1; iss_rd = 5'd2;
        edge_step();
        next_low();
        idle();
        set_rd(5'd2, 5'd12);
        #1;
        check("first_edge_write", rd_data[31:0], 64'hA5A5_0001);
        check("first_edge_issue", busy_vec, 64'h4);
        check("first_edge_rd_busy", rd_busy, 64'h2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
